// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx                                                          |
// | Purpose : Byte-serial UART transmitter (8N1, LSB first). Accepts one byte  |
// |           on each rising edge of send while idle and returns a one-cycle   |
// |           txdone pulse when the stop bit completes.                        |
// | Ports   : clk    - system clock, rising edge active                        |
// |           rst    - asynchronous active-high reset                          |
// |           txdata - byte to transmit, sampled on the acceptance cycle       |
// |           send   - transmit request, rising edge significant               |
// |           txdone - one-cycle pulse at the end of the stop bit              |
// |           busy   - high from acceptance until txdone                       |
// |           tx     - registered serial line, idle high                       |
// | Config  : define UART_TX_PARITY_EN to insert an even-parity bit between    |
// |           D7 and the stop bit (11-bit frame).                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txdata,
  input  logic       send,
  output logic       txdone,
  output logic       busy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int c_CNT_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_cfg_check
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  logic [2:0]         r_state;
  logic               r_send_q;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic [c_CNT_W-1:0] r_baud_cnt;
  logic               r_tx;
  logic               r_txdone;
  logic               r_busy;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic w_req;
  logic w_bit_end;

  // Edge detect: the upstream buffer holds send high across a whole byte.
  assign w_req     = send & ~r_send_q;
  assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

  // tx is registered and loaded with the value of the bit being entered, so
  // the line changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_send_q   <= 1'b0;
      r_shift    <= 8'h00;
      r_bit_idx  <= 3'd0;
      r_baud_cnt <= '0;
      r_tx       <= 1'b1;
      r_txdone   <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_send_q <= send;
      r_txdone <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_req) begin
            r_shift    <= txdata;
            r_bit_idx  <= 3'd0;
            r_baud_cnt <= '0;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_state    <= c_ST_START;
`ifdef UART_TX_PARITY_EN
            r_parity   <= ^txdata;
`endif
          end
        end

        c_ST_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_state    <= c_ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        c_ST_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= c_ST_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= c_ST_STOP;
`endif
            end else begin
              // Next bit is shift[1]; present it now as it lands in shift[0].
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        c_ST_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_state    <= c_ST_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
`endif

        c_ST_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_txdone   <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= c_ST_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign tx     = r_tx;
  assign txdone = r_txdone;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_tx                                                       |
// | Purpose : Self-checking bench for uart_tx with CLK_FREQ=16, BAUD=4 (C=4).  |
// |           Stimulus pushes expected bytes into a queue; a line monitor      |
// |           decodes each frame on tx and compares against the queue.        |
// | Config  : honours UART_TX_PARITY_EN (11-bit frames, parity bit checked).   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * C;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       send   = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic       txdone;
  logic       busy;
  logic       tx;

  uart_tx #(
    .CLK_FREQ (16),
    .BAUD     (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .txdata (txdata),
    .send   (send),
    .txdone (txdone),
    .busy   (busy),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  bit         mon_busy = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (txdone === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Line monitor: a low tx while out of reset marks a start bit. Samples
  // index j are taken after edge k+j, where k is the acceptance edge.
  initial begin : monitor
    logic       samp [64];
    logic       dn   [64];
    logic       bz   [64];
    bit         aborted;
    int         hold_err;
    int         busy_err;
    int         done_first;
    logic [7:0] got;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        mon_busy = 1'b1;
        aborted  = 1'b0;
        for (int j = 0; j < FRAME_CYC + 2; j++) begin
          if (j > 0) @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          samp[j] = tx;
          dn[j]   = txdone;
          bz[j]   = busy;
        end
        if (!aborted) begin
          hold_err = 0;
          for (int b = 0; b < NBITS; b++)
            for (int i = 1; i < C; i++)
              if (samp[b*C+i] !== samp[b*C]) hold_err++;
          chk("bit_hold_errors", 32'(hold_err), 32'd0);
          chk("stop_bit", 32'(samp[(NBITS-1)*C]), 32'd1);
          got = 8'h00;
          for (int b = 0; b < 8; b++) got[b] = samp[(b+1)*C];
          done_first = -1;
          for (int j = 0; j < FRAME_CYC + 2; j++)
            if (dn[j] === 1'b1 && done_first < 0) done_first = j;
          chk("txdone_cycle", 32'(done_first), 32'(FRAME_CYC));
          chk("txdone_width", 32'(dn[FRAME_CYC+1]), 32'd0);
          busy_err = 0;
          for (int j = 0; j < FRAME_CYC; j++)
            if (bz[j] !== 1'b1) busy_err++;
          if (bz[FRAME_CYC] !== 1'b0) busy_err++;
          chk("busy_errors", 32'(busy_err), 32'd0);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: got 0x%0h required no frame", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_fail++;
              $display("FAIL frame_data: got 0x%0h required 0x%0h", got, want);
            end
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", 32'(samp[9*C]), 32'(^want));
`endif
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Called at a negedge; send is high for exactly one rising clock edge.
  task automatic send_byte(input logic [7:0] v, input bit push);
    if (push) exp_q.push_back(v);
    txdata = v;
    send   = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_start", 32'(tx), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || mon_busy) && n < budget);
    n_checks++;
    if (exp_q.size() != 0 || mon_busy) begin
      n_fail++;
      $display("FAIL wait_idle: got %0d frames outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lows;
    int d0;
    bit seen;

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_txdone", 32'(txdone), 32'd0);
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("idle_tx_low_cycles", 32'(lows), 32'd0);

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1
    send_byte(8'hA5, 1'b1);
    wait_idle(100);

    // send held high: exactly one frame
    d0 = done_cnt;
    exp_q.push_back(8'h3C);
    txdata = 8'h3C;
    send   = 1'b1;
    @(negedge clk);
    chk("held_accept_start", 32'(tx), 32'd0);
    repeat (200) @(negedge clk);
    send = 1'b0;
    chk("held_txdone_count", 32'(done_cnt - d0), 32'd1);
    wait_idle(100);

    // Back-to-back: re-raise send the cycle after txdone
    send_byte(8'h11, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (txdone === 1'b1) seen = 1'b1;
    end
    chk("b2b_txdone_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("b2b_gap_idle", 32'(tx), 32'd1);
    send_byte(8'h22, 1'b1);
    wait_idle(200);

    // Request while busy is ignored; txdata changes do not corrupt frame
    d0 = done_cnt;
    send_byte(8'h00, 1'b1);
    repeat (9) @(negedge clk);
    txdata = 8'hFF;
    send   = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_idle(100);
    repeat (60) @(negedge clk);
    chk("busy_req_txdone_count", 32'(done_cnt - d0), 32'd1);

    // Reset mid-frame (tx is low on data bit 3 of 0x55 here)
    d0 = done_cnt;
    send_byte(8'h55, 1'b0);
    repeat (16) @(negedge clk);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_txdone", 32'(txdone), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_txdone", 32'(done_cnt - d0), 32'd0);
    send_byte(8'h81, 1'b1);
    wait_idle(100);

    // Parity patterns (parity bit checked when compiled in)
    send_byte(8'h07, 1'b1);
    wait_idle(100);
    send_byte(8'h03, 1'b1);
    wait_idle(100);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
